// File: rtl/encoder_8to3_reg.sv
`default_nettype none
// ============================================================================
//  Module   : encoder_8to3_reg
//  Brief    : Registered 8-to-3 priority encoder with a sticky request
//             register and a valid/ack presentation handshake. The highest
//             pending index is presented on {A,B,C}; acknowledged codes are
//             retired and the next one follows without an idle bubble.
//  Config   : ENC_EDGE_DETECT_EN - when defined, a request is a high-to-low
//             transition of Y_n[i]; otherwise a low level on Y_n[i].
//  Revision : 1.0 - initial release
// ============================================================================
module encoder_8to3_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] Y_n,
    input  logic       en,
    input  logic       ack,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       valid,
    output logic       multi
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t      r_state;
    logic [7:0]  r_pending;
    logic [2:0]  r_code;
    logic        r_multi;

    logic [7:0]  w_request;
    logic [7:0]  w_set;
    logic [7:0]  w_code_mask;
    logic        w_ack_fire;
    logic        w_keep;
    logic [7:0]  w_pool;
    logic [2:0]  w_idle_pick;
    logic [7:0]  w_idle_rest;
    logic [2:0]  w_next_pick;
    logic [7:0]  w_next_rest;
    logic [7:0]  w_pending_next;

    // Index of the highest set bit; zero when the vector is empty
    // (callers only use the result when the vector is nonzero).
    function automatic logic [2:0] f_highest(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [7:0] f_onehot(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

`ifdef ENC_EDGE_DETECT_EN
    logic [7:0] r_prev_n;

    // Track the previous request-line levels so only falling edges count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_n <= 8'hFF;
        end else begin
            r_prev_n <= Y_n;
        end
    end

    assign w_request = r_prev_n & ~Y_n;
`else
    assign w_request = ~Y_n;
`endif

    assign w_set       = en ? w_request : 8'h00;
    assign w_code_mask = f_onehot(r_code);
    assign w_ack_fire  = (r_state == ST_PRESENT) & ack;
    // A fresh request for the code being retired keeps that bit pending.
    assign w_keep      = |(w_set & w_code_mask);
    // Pre-edge requests still waiting once the presented code is retired.
    assign w_pool      = r_pending & ~w_code_mask;

    // Selection helpers for the IDLE load and the post-ack load.
    always_comb begin
        w_idle_pick    = f_highest(r_pending);
        w_idle_rest    = r_pending & ~f_onehot(w_idle_pick);
        w_next_pick    = f_highest(w_pool);
        w_next_rest    = w_pool & ~f_onehot(w_next_pick);
        w_pending_next = w_ack_fire ? (w_pool | w_set) : (r_pending | w_set);
    end

    // Sticky request register: new requests OR in every cycle, ack retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 8'h00;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // Presentation FSM; code and multi only change when a code is loaded.
    // After an ack, multi also counts the retired bit when a same-cycle
    // request kept it pending behind the newly loaded code.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_code  <= 3'b000;
            r_multi <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|r_pending) begin
                        r_code  <= w_idle_pick;
                        r_multi <= |w_idle_rest;
                        r_state <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (ack) begin
                        if (|w_pool) begin
                            r_code  <= w_next_pick;
                            r_multi <= (|w_next_rest) | w_keep;
                        end else if (w_keep) begin
                            r_multi <= 1'b0;
                        end else begin
                            r_multi <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign {A, B, C} = r_code;
    assign valid     = (r_state == ST_PRESENT);
    assign multi     = r_multi;

endmodule
`default_nettype wire

// File: tb/tb_encoder_8to3_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_encoder_8to3_reg
//  Brief    : Self-checking bench for encoder_8to3_reg: directed vector table,
//             held-request sequence and randomized run against a model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_encoder_8to3_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       ack;
    logic [7:0] Y_n;
    logic       A, B, C, valid, multi;

    always #5 clk = ~clk;

    encoder_8to3_reg dut (
        .clk   (clk),
        .rst   (rst),
        .Y_n   (Y_n),
        .en    (en),
        .ack   (ack),
        .A     (A),
        .B     (B),
        .C     (C),
        .valid (valid),
        .multi (multi)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: set of waiting request indices plus the
    // currently presented code.
    bit m_pend [8];
    bit m_valid;
    int m_code;
    bit m_multi;
`ifdef ENC_EDGE_DETECT_EN
    logic [7:0] m_prev;
`endif

    // Highest index present in p other than skip, or -1.
    function automatic int top_excl(input bit p [8], input int skip);
        for (int i = 7; i >= 0; i--) begin
            if (p[i] && i != skip) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic e, input logic a,
                              input logic [7:0] y);
        bit newreq [8];
        bit fell;
        bit keep;
        int pick;
        if (r) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_valid = 1'b0;
            m_code  = 0;
            m_multi = 1'b0;
`ifdef ENC_EDGE_DETECT_EN
            m_prev  = 8'hFF;
`endif
            return;
        end
        for (int i = 0; i < 8; i++) begin
`ifdef ENC_EDGE_DETECT_EN
            fell = (m_prev[i] == 1'b1) && (y[i] == 1'b0);
`else
            fell = (y[i] == 1'b0);
`endif
            newreq[i] = e && fell;
        end
        if (!m_valid) begin
            pick = top_excl(m_pend, -1);
            if (pick >= 0) begin
                m_valid = 1'b1;
                m_code  = pick;
                m_multi = (top_excl(m_pend, pick) >= 0);
            end
        end else if (a) begin
            keep = newreq[m_code];
            m_pend[m_code] = keep;
            pick = top_excl(m_pend, m_code);
            if (pick < 0 && keep) pick = m_code;
            if (pick < 0) begin
                m_valid = 1'b0;
                m_multi = 1'b0;
            end else begin
                m_multi = (top_excl(m_pend, pick) >= 0);
                m_code  = pick;
            end
        end
        for (int i = 0; i < 8; i++) m_pend[i] = m_pend[i] | newreq[i];
`ifdef ENC_EDGE_DETECT_EN
        m_prev = y;
`endif
    endtask

    // Drive one cycle of inputs, advance the model, sample after the edge.
    task automatic apply(input logic r, input logic e, input logic a,
                         input logic [7:0] y);
        rst = r; en = e; ack = a; Y_n = y;
        model_step(r, e, a, y);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic ev,
                         input logic [2:0] ec, input logic em);
        n_vec++;
        if ({valid, A, B, C, multi} !== {ev, ec, em}) begin
            n_bad++;
            $display("FAIL %s: got valid=%0b code=%0d multi=%0b, want valid=%0b code=%0d multi=%0b",
                     name, valid, {A, B, C}, multi, ev, ec, em);
        end
    endtask

    task automatic check_model(input string name);
        check(name, m_valid, 3'(m_code), m_multi);
    endtask

    typedef struct {
        string      name;
        logic       rst;
        logic       en;
        logic       ack;
        logic [7:0] y_n;
        logic       exp_valid;
        logic [2:0] exp_code;
        logic       exp_multi;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input string nm, input logic r, input logic e,
                       input logic a, input logic [7:0] y, input logic v,
                       input logic [2:0] c, input logic m);
        vec_t t;
        t.name = nm; t.rst = r; t.en = e; t.ack = a; t.y_n = y;
        t.exp_valid = v; t.exp_code = c; t.exp_multi = m;
        tbl.push_back(t);
    endtask

    initial begin
        int pres_cnt;
        int pres_exp;
        logic       r_r, r_e, r_a;
        logic [7:0] r_y;

        rst = 1'b1; en = 1'b1; ack = 1'b0; Y_n = 8'h00;

        //   name           rst en ack Y_n     valid code multi
        add("reset0",       1, 1, 0, 8'h00,  0, 3'd0, 0);
        add("reset1",       1, 1, 0, 8'h00,  0, 3'd0, 0);
        add("post_reset",   0, 1, 0, 8'hFF,  0, 3'd0, 0);
        add("single_cap",   0, 1, 0, 8'hFB,  0, 3'd0, 0);
        add("single_pres",  0, 1, 0, 8'hFF,  1, 3'd2, 0);
        add("single_hold",  0, 1, 0, 8'hFF,  1, 3'd2, 0);
        add("single_ack",   0, 1, 1, 8'hFF,  0, 3'd2, 0);
        add("idle_hold",    0, 1, 0, 8'hFF,  0, 3'd2, 0);
        add("prio_cap",     0, 1, 0, 8'h7E,  0, 3'd2, 0);
        add("prio_pres",    0, 1, 0, 8'hFF,  1, 3'd7, 1);
        add("b2b_next",     0, 1, 1, 8'hFF,  1, 3'd0, 0);
        add("b2b_idle",     0, 1, 1, 8'hFF,  0, 3'd0, 0);
        add("b2b_rest",     0, 1, 0, 8'hFF,  0, 3'd0, 0);
        add("coll_cap",     0, 1, 0, 8'hF7,  0, 3'd0, 0);
        add("coll_pres",    0, 1, 0, 8'hFF,  1, 3'd3, 0);
        add("coll_keep",    0, 1, 1, 8'hF7,  1, 3'd3, 0);
        add("coll_retire",  0, 1, 1, 8'hFF,  0, 3'd3, 0);
        add("coll_rest",    0, 1, 0, 8'hFF,  0, 3'd3, 0);
        add("en_gate0",     0, 0, 0, 8'h00,  0, 3'd3, 0);
        add("en_gate1",     0, 0, 0, 8'h00,  0, 3'd3, 0);
        add("en_gate2",     0, 0, 0, 8'h00,  0, 3'd3, 0);
        add("en_gate3",     0, 0, 0, 8'h00,  0, 3'd3, 0);
        add("en_release",   0, 0, 0, 8'hFF,  0, 3'd3, 0);
        add("en_cap",       0, 1, 0, 8'h7F,  0, 3'd3, 0);
        add("en_pres",      0, 1, 0, 8'hFF,  1, 3'd7, 0);
        add("en_ack",       0, 1, 1, 8'hFF,  0, 3'd7, 0);
        add("mid_cap",      0, 1, 0, 8'h7E,  0, 3'd7, 0);
        add("mid_pres",     0, 1, 0, 8'hFF,  1, 3'd7, 1);
        add("mid_reset",    1, 1, 0, 8'hFF,  0, 3'd0, 0);
        add("mid_after0",   0, 1, 0, 8'hFF,  0, 3'd0, 0);
        add("mid_after1",   0, 1, 0, 8'hFF,  0, 3'd0, 0);
        add("ack_no_valid", 0, 1, 1, 8'hFF,  0, 3'd0, 0);

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].en, tbl[i].ack, tbl[i].y_n);
            check(tbl[i].name, tbl[i].exp_valid, tbl[i].exp_code, tbl[i].exp_multi);
        end

        // Request held low for five cycles with ack always asserted.
        pres_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            apply(1'b0, 1'b1, 1'b1, (i < 5) ? 8'hFE : 8'hFF);
            check_model("held_seq");
            if (valid === 1'b1 && {A, B, C} === 3'd0) pres_cnt++;
        end
`ifdef ENC_EDGE_DETECT_EN
        pres_exp = 1;
`else
        pres_exp = 4;
`endif
        n_vec++;
        if (pres_cnt != pres_exp) begin
            n_bad++;
            $display("FAIL held_presentations: got %0d, want %0d", pres_cnt, pres_exp);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            r_r = ($urandom_range(0, 47) == 0);
            r_e = ($urandom_range(0, 3) != 0);
            r_a = ($urandom_range(0, 1) == 1);
            r_y = 8'($urandom | $urandom);
            apply(r_r, r_e, r_a, r_y);
            check_model("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
